pcr_timebase: RTL and testbench

- Consumer end of the divided-clock interface: takes the 27 MHz toggle output of the clock divider in the 108 MHz clk2 domain.
- Turns each rising edge of that toggle into a one-cycle 27 MHz tick enable.
- Uses the tick to advance an MPEG-2 PCR-format system time clock (33-bit base, 9-bit extension mod 300).
- Includes a watchdog that flags loss of the incoming toggle; feeds PCR stamping/QoS jitter measurement.

---
 rtl/pcr_pkg.sv | 42 ++++
 rtl/pcr_timebase_if.sv | 38 +++
 rtl/pcr_timebase_rise_edge_detect.sv | 69 ++++++
 rtl/pcr_timebase.sv | 97 +++++++++
 tb/tb_pcr_timebase.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcr_pkg.sv
// ----------------------------------------------------------------------------
// pcr_pkg
// Shared MPEG-2 PCR definitions for the timebase and for the PCR stamping and
// insertion blocks that will sit on top of it.
//   PCR_BASE_W   width of the 90 kHz-equivalent base field (33 bits)
//   PCR_EXT_W    width of the 27 MHz extension field (9 bits)
//   PCR_EXT_MOD  extension modulus; the extension counts 0..299
//   pcr_t        packed {base, ext} pair
//   pcrIncrement advance a PCR value by one 27 MHz tick
//   extLegal     true when an extension value is inside 0..299
// ----------------------------------------------------------------------------
package pcr_pkg;

    localparam int PCR_BASE_W  = 33;
    localparam int PCR_EXT_W   = 9;
    localparam int PCR_EXT_MOD = 300;

    typedef struct packed {
        logic [PCR_BASE_W-1:0] base;
        logic [PCR_EXT_W-1:0]  ext;
    } pcr_t;

    // One 27 MHz step: the extension rolls over at 300 and carries into the
    // base, which itself wraps silently at 2^33.
    function automatic pcr_t pcrIncrement(input pcr_t cur);
        pcr_t nxt;
        nxt = cur;
        if (cur.ext == PCR_EXT_W'(PCR_EXT_MOD - 1)) begin
            nxt.ext  = '0;
            nxt.base = cur.base + PCR_BASE_W'(1);
        end else begin
            nxt.ext  = cur.ext + PCR_EXT_W'(1);
        end
        return nxt;
    endfunction

    // A 9-bit field can hold 300..511, which are not valid extensions.
    function automatic logic extLegal(input logic [PCR_EXT_W-1:0] ext);
        return ext < PCR_EXT_W'(PCR_EXT_MOD);
    endfunction

endpackage

// File: rtl/pcr_timebase_if.sv
// ----------------------------------------------------------------------------
// pcr_timebase_if
// Bundle between the PCR timebase and whoever feeds/consumes it.
//   clk_pulse_in  divided 27 MHz toggle into the timebase
//   load          one-cycle strobe to load load_base/load_ext
//   load_base     PCR base to load
//   load_ext      PCR extension to load (legal 0..299)
//   tick          one-cycle 27 MHz enable out of the timebase
//   pcr_base      current PCR base
//   pcr_ext       current PCR extension
//   clk_lost      watchdog flag: the toggle has stopped
//   load_err      one-cycle pulse: a load was rejected
// Modports: master drives the toggle and load request, slave is the timebase.
// ----------------------------------------------------------------------------
interface pcr_timebase_if;
    import pcr_pkg::*;

    logic                  clk_pulse_in;
    logic                  load;
    logic [PCR_BASE_W-1:0] load_base;
    logic [PCR_EXT_W-1:0]  load_ext;
    logic                  tick;
    logic [PCR_BASE_W-1:0] pcr_base;
    logic [PCR_EXT_W-1:0]  pcr_ext;
    logic                  clk_lost;
    logic                  load_err;

    modport master (
        output clk_pulse_in, load, load_base, load_ext,
        input  tick, pcr_base, pcr_ext, clk_lost, load_err
    );

    modport slave (
        input  clk_pulse_in, load, load_base, load_ext,
        output tick, pcr_base, pcr_ext, clk_lost, load_err
    );

endinterface

// File: rtl/pcr_timebase_rise_edge_detect.sv
// ----------------------------------------------------------------------------
// rise_edge_detect
// Turns rising edges of a toggle-style strobe into a one-cycle pulse.
// Optional build macro: PCR_TIMEBASE_SYNC_EN
//   defined   -> i_toggle goes through a 2-flop synchronizer first, so the
//                source may be asynchronous (pulse 3 cycles after the edge)
//   undefined -> i_toggle is assumed to come from a register in this clock
//                domain and is used directly (pulse 1 cycle after the edge)
// Ports:
//   clk       sampling clock
//   rst       synchronous active-high reset
//   i_toggle  toggle input
//   o_rise    combinational rise indication for the current cycle; lets the
//             parent update state on the same edge that raises o_pulse
//   o_pulse   registered one-cycle rise pulse
// History and synchronizer flops reset to 1 to match the divider's reset
// level, so reset release never looks like a rising edge.
// ----------------------------------------------------------------------------
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_toggle,
    output logic o_rise,
    output logic o_pulse
);

    logic w_sampled;
    logic w_rise;
    logic r_prev;
    logic r_pulse;

`ifdef PCR_TIMEBASE_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-stage synchronizer for an asynchronous toggle source.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_toggle;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sampled = r_sync2;
`else
    assign w_sampled = i_toggle;
`endif

    assign w_rise = w_sampled & ~r_prev;

    // History register plus the registered pulse; falling edges never
    // produce a pulse because only high-after-low is detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 1'b1;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= w_sampled;
            r_pulse <= w_rise;
        end
    end

    assign o_rise  = w_rise;
    assign o_pulse = r_pulse;

endmodule

// File: rtl/pcr_timebase.sv
// ----------------------------------------------------------------------------
// pcr_timebase
// Consumer end of the 27 MHz divided-clock toggle in the 108 MHz clk2 domain.
// Each rising edge of the toggle produces a one-cycle tick and advances an
// MPEG-2 PCR system time clock (33-bit base, 9-bit extension mod 300).
// A watchdog raises clk_lost when no rising edge has been seen for
// TIMEOUT_CYCLES clk2 cycles.
// Optional build macro: PCR_TIMEBASE_SYNC_EN adds a 2-flop input
// synchronizer in front of edge detection (see rise_edge_detect).
// Parameters:
//   FREQUENCY_IN    clk2 frequency in Hz
//   FREQUENCY_OUT   nominal toggle frequency in Hz
//   TIMEOUT_CYCLES  quiet cycles before clk_lost; floored at 2*RATIO
// Ports:
//   clk2  108 MHz system clock
//   rst   synchronous active-high reset
//   bus   pcr_timebase_if.slave (toggle in, load request, tick/PCR/flags out)
// ----------------------------------------------------------------------------
module pcr_timebase
    import pcr_pkg::*;
#(
    parameter real FREQUENCY_IN   = 108.0e6,
    parameter real FREQUENCY_OUT  = 27.0e6,
    parameter int  TIMEOUT_CYCLES = 4 * int'(FREQUENCY_IN / FREQUENCY_OUT)
) (
    input  logic          clk2,
    input  logic          rst,
    pcr_timebase_if.slave bus
);

    localparam int RATIO    = int'(FREQUENCY_IN / FREQUENCY_OUT);
    // Anything below two toggle periods would trip on normal jitter.
    localparam int WD_LIMIT = (TIMEOUT_CYCLES < 2 * RATIO) ? 2 * RATIO : TIMEOUT_CYCLES;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

    logic            w_rise;
    logic            w_tick;
    logic            w_loadValid;
    logic            w_loadBad;
    pcr_t            r_pcr;
    logic            r_loadErr;
    logic [WD_W-1:0] r_wdCount;
    logic            r_clkLost;

    rise_edge_detect u_riseEdge (
        .clk      (clk2),
        .rst      (rst),
        .i_toggle (bus.clk_pulse_in),
        .o_rise   (w_rise),
        .o_pulse  (w_tick)
    );

    assign w_loadValid = bus.load & extLegal(bus.load_ext);
    assign w_loadBad   = bus.load & ~extLegal(bus.load_ext);

    // PCR counter. A valid load wins over a coincident rise, dropping that
    // tick's increment; a rejected load leaves the counter running as if no
    // load had been requested and only raises load_err for one cycle.
    always_ff @(posedge clk2) begin
        if (rst) begin
            r_pcr     <= '0;
            r_loadErr <= 1'b0;
        end else begin
            if (w_loadValid) begin
                r_pcr <= '{base: bus.load_base, ext: bus.load_ext};
            end else if (w_rise) begin
                r_pcr <= pcrIncrement(r_pcr);
            end
            r_loadErr <= w_loadBad;
        end
    end

    // Watchdog. Counts quiet cycles and saturates at the limit; clk_lost is
    // registered so that it is high exactly while the count sits at the
    // limit. A rise clears both on the edge that raises tick. There is no
    // free-running fallback: the PCR simply stalls while the toggle is gone.
    always_ff @(posedge clk2) begin
        if (rst) begin
            r_wdCount <= '0;
            r_clkLost <= 1'b0;
        end else if (w_rise) begin
            r_wdCount <= '0;
            r_clkLost <= 1'b0;
        end else if (r_wdCount != WD_MAX) begin
            r_wdCount <= r_wdCount + WD_W'(1);
            r_clkLost <= (r_wdCount == WD_MAX - WD_W'(1));
        end
    end

    assign bus.tick     = w_tick;
    assign bus.pcr_base = r_pcr.base;
    assign bus.pcr_ext  = r_pcr.ext;
    assign bus.clk_lost = r_clkLost;
    assign bus.load_err = r_loadErr;

endmodule

// File: tb/tb_pcr_timebase.sv
// ----------------------------------------------------------------------------
// tb_pcr_timebase
// Self-checking bench for pcr_timebase. A behavioural model tracks the PCR as
// a single tick count (base*300+ext) and the watchdog as "cycles since the
// last rise"; the optional synchronizer is modelled as a plain input delay.
// ----------------------------------------------------------------------------
module tb_pcr_timebase;
    import pcr_pkg::*;

    localparam int TIMEOUT = 16;
`ifdef PCR_TIMEBASE_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif
    localparam int LAT = SYNC_STAGES + 1;
    localparam longint unsigned PCR_SPAN = 64'd300 * (64'd1 << 33);

    logic clk2 = 1'b0;
    logic rst  = 1'b1;

    pcr_timebase_if bus ();

    pcr_timebase #(
        .FREQUENCY_IN   (108.0e6),
        .FREQUENCY_OUT  (27.0e6),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (bus)
    );

    // 108 MHz-ish clock; absolute period is irrelevant to the checks.
    always #5 clk2 = ~clk2;

    int checks   = 0;
    int failures = 0;
    int edgeNo   = 0;
    int lastTickEdge = 0;

    longint unsigned mTotal;
    bit  mTick;
    bit  mLost;
    bit  mErr;
    bit  mPrev;
    int  mQuiet;
    bit  mPipe[$];

    typedef struct {
        bit          r;
        bit          p;
        bit          ld;
        logic [32:0] lb;
        logic [8:0]  le;
        bit          eTick;
        logic [32:0] eBase;
        logic [8:0]  eExt;
        bit          eLost;
        bit          eErr;
    } vec_t;

    vec_t vecs[$];

    function automatic void modelReset();
        mTotal = 0;
        mTick  = 0;
        mLost  = 0;
        mErr   = 0;
        mPrev  = 1;
        mQuiet = 0;
        mPipe.delete();
        for (int i = 0; i < SYNC_STAGES; i++) mPipe.push_back(1'b1);
    endfunction

    // One clk2 edge of the reference behaviour.
    function automatic void modelEdge(bit r, bit p, bit ld, logic [32:0] lb, logic [8:0] le);
        bit s;
        bit rise;
        if (r) begin
            modelReset();
            return;
        end
        mPipe.push_back(p);
        s     = mPipe.pop_front();
        rise  = s && !mPrev;
        mPrev = s;
        mTick = rise;
        mErr  = ld && (le >= 9'd300);
        if (ld && le < 9'd300)
            mTotal = 64'(lb) * 64'd300 + 64'(le);
        else if (rise)
            mTotal = (mTotal + 64'd1) % PCR_SPAN;
        if (rise) mQuiet = 0;
        else if (mQuiet < TIMEOUT) mQuiet = mQuiet + 1;
        mLost = (mQuiet == TIMEOUT);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (edge %0d)", name, actual, expected, edgeNo);
        end
    endtask

    // Drive one cycle's inputs, clock once, then compare against the model.
    task automatic applyStimulus(input bit r, input bit p, input bit ld,
                                 input logic [32:0] lb, input logic [8:0] le);
        rst              = r;
        bus.clk_pulse_in = p;
        bus.load         = ld;
        bus.load_base    = lb;
        bus.load_ext     = le;
        @(posedge clk2);
        #1;
        edgeNo++;
        modelEdge(r, p, ld, lb, le);
        if (bus.tick === 1'b1) lastTickEdge = edgeNo;
        checkOutput("mdlTick", bus.tick, mTick);
        checkOutput("mdlBase", bus.pcr_base, 33'(mTotal / 64'd300));
        checkOutput("mdlExt", bus.pcr_ext, 9'(mTotal % 64'd300));
        checkOutput("mdlLost", bus.clk_lost, mLost);
        checkOutput("mdlErr", bus.load_err, mErr);
    endtask

    task automatic idle(input int n, input bit p);
        repeat (n) applyStimulus(1'b0, p, 1'b0, '0, '0);
    endtask

    // Low sample followed by high; the optional load rides on the edge
    // where the rise is seen, so the last call returns on the tick edge.
    task automatic makeRise(input bit ld, input logic [32:0] lb, input logic [8:0] le);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        for (int k = 1; k <= LAT; k++) begin
            if (k == LAT) begin
                applyStimulus(1'b0, 1'b1, ld, lb, le);
            end else begin
                applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
                checkOutput("riseLatency", bus.tick, 1'b0);
            end
        end
    endtask

    function automatic vec_t mk(bit r, bit ld, logic [32:0] lb, logic [8:0] le,
                                logic [32:0] eb, logic [8:0] ee, bit el, bit eer);
        vec_t v;
        v.r = r; v.p = 1'b1; v.ld = ld; v.lb = lb; v.le = le;
        v.eTick = 1'b0; v.eBase = eb; v.eExt = ee; v.eLost = el; v.eErr = eer;
        return v;
    endfunction

    // Bound on total runtime so a wedged run still reports.
    initial begin
        #1_000_000;
        $display("[TB] FAIL globalTimeout: actual=expired required=finished");
        $fatal(1, "[TB] timeout");
    end

    // Main sequence: table, hand-written corners, nominal stream, random.
    initial begin
        int  started;
        int  window;
        int  tickCount;
        bit  prevTick;
        bit  wideSeen;
        bit  lostSeen;
        int  lostAt;
        logic [8:0]  snapExt;
        logic [32:0] snapBase;
        logic [63:0] rnd;
        bit  p;
        int  hold;

        modelReset();
        bus.clk_pulse_in = 1'b1;
        bus.load = 1'b0;
        bus.load_base = '0;
        bus.load_ext = '0;

        // Toggle held high throughout: only loads and the watchdog move.
        vecs.push_back(mk(1, 0, 33'd0, 9'd0, 33'd0, 9'd0, 0, 0));
        vecs.push_back(mk(1, 0, 33'd0, 9'd0, 33'd0, 9'd0, 0, 0));
        vecs.push_back(mk(0, 1, 33'd5, 9'd10, 33'd5, 9'd10, 0, 0));
        vecs.push_back(mk(0, 1, 33'd7, 9'd300, 33'd5, 9'd10, 0, 1));
        vecs.push_back(mk(0, 0, 33'd0, 9'd0, 33'd5, 9'd10, 0, 0));
        vecs.push_back(mk(0, 1, 33'h1_FFFF_FFFF, 9'd299, 33'h1_FFFF_FFFF, 9'd299, 0, 0));
        vecs.push_back(mk(0, 1, 33'd123456789, 9'd0, 33'd123456789, 9'd0, 0, 0));
        vecs.push_back(mk(0, 1, 33'd1, 9'd511, 33'd123456789, 9'd0, 0, 1));
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(0, 0, 33'd0, 9'd0, 33'd123456789, 9'd0, 0, 0));
        vecs.push_back(mk(0, 0, 33'd0, 9'd0, 33'd123456789, 9'd0, 1, 0));
        vecs.push_back(mk(0, 1, 33'd42, 9'd299, 33'd42, 9'd299, 1, 0));
        vecs.push_back(mk(0, 0, 33'd0, 9'd0, 33'd42, 9'd299, 1, 0));
        vecs.push_back(mk(1, 1, 33'd9, 9'd9, 33'd0, 9'd0, 0, 0));
        vecs.push_back(mk(0, 1, 33'd42, 9'd299, 33'd42, 9'd299, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].p, vecs[i].ld, vecs[i].lb, vecs[i].le);
            checkOutput("vecTick", bus.tick, vecs[i].eTick);
            checkOutput("vecBase", bus.pcr_base, vecs[i].eBase);
            checkOutput("vecExt", bus.pcr_ext, vecs[i].eExt);
            checkOutput("vecLost", bus.clk_lost, vecs[i].eLost);
            checkOutput("vecErr", bus.load_err, vecs[i].eErr);
        end

        // Extension carry 299 -> base+1, and tick exactly one cycle wide.
        makeRise(1'b0, '0, '0);
        checkOutput("carryTick", bus.tick, 1'b1);
        checkOutput("carryBase", bus.pcr_base, 33'd43);
        checkOutput("carryExt", bus.pcr_ext, 9'd0);
        checkOutput("carryLost", bus.clk_lost, 1'b0);
        idle(1, 1'b1);
        checkOutput("tickWidth", bus.tick, 1'b0);
        checkOutput("noFallExt", bus.pcr_ext, 9'd0);

        // Load coincident with a rise: tick pulses, increment dropped.
        makeRise(1'b1, 33'd5, 9'd10);
        checkOutput("ldRiseTick", bus.tick, 1'b1);
        checkOutput("ldRiseBase", bus.pcr_base, 33'd5);
        checkOutput("ldRiseExt", bus.pcr_ext, 9'd10);
        idle(1, 1'b1);
        checkOutput("ldRiseHold", bus.pcr_ext, 9'd10);

        // Full wrap of the 33-bit base.
        applyStimulus(1'b0, 1'b1, 1'b1, 33'h1_FFFF_FFFF, 9'd299);
        makeRise(1'b0, '0, '0);
        checkOutput("wrapTick", bus.tick, 1'b1);
        checkOutput("wrapBase", bus.pcr_base, 33'd0);
        checkOutput("wrapExt", bus.pcr_ext, 9'd0);

        // Rejected load coincident with a rise: counter still advances.
        makeRise(1'b1, 33'd77, 9'd300);
        checkOutput("badLdTick", bus.tick, 1'b1);
        checkOutput("badLdErr", bus.load_err, 1'b1);
        checkOutput("badLdExt", bus.pcr_ext, 9'd1);
        checkOutput("badLdBase", bus.pcr_base, 33'd0);
        idle(1, 1'b1);
        checkOutput("badLdErrPulse", bus.load_err, 1'b0);

        // Nominal divider stream: rise every 4 cycles, 1200-cycle window.
        applyStimulus(1'b0, 1'b1, 1'b1, 33'd0, 9'd0);
        started = 0; window = 0; tickCount = 0;
        prevTick = 0; wideSeen = 0; lostSeen = 0;
        for (int cyc = 0; cyc < 1400 && window < 1200; cyc++) begin
            applyStimulus(1'b0, (cyc % 4) >= 2, 1'b0, '0, '0);
            if (!started && bus.tick === 1'b1) started = 1;
            if (started) begin
                window++;
                if (bus.tick === 1'b1) tickCount++;
                if (prevTick && bus.tick === 1'b1) wideSeen = 1;
                if (bus.clk_lost !== 1'b0) lostSeen = 1;
            end else if (cyc >= 20) begin
                break;
            end
            prevTick = (bus.tick === 1'b1);
        end
        checkOutput("streamStarted", started, 1);
        checkOutput("streamTicks", tickCount, 300);
        checkOutput("streamBase", bus.pcr_base, 33'd1);
        checkOutput("streamExt", bus.pcr_ext, 9'd0);
        checkOutput("streamWide", wideSeen, 1'b0);
        checkOutput("streamLost", lostSeen, 1'b0);

        // Stop the toggle; clk_lost must rise 16 cycles after the last tick.
        lostAt = -1;
        for (int k = 0; k < 24; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
            if (bus.clk_lost === 1'b1 && lostAt < 0) lostAt = edgeNo - lastTickEdge;
        end
        checkOutput("lostDelay", lostAt, TIMEOUT);
        checkOutput("lostHeld", bus.clk_lost, 1'b1);
        snapExt  = bus.pcr_ext;
        snapBase = bus.pcr_base;
        makeRise(1'b0, '0, '0);
        checkOutput("resumeTick", bus.tick, 1'b1);
        checkOutput("resumeLost", bus.clk_lost, 1'b0);
        checkOutput("resumeExt", bus.pcr_ext, snapExt + 9'd1);
        checkOutput("resumeBase", bus.pcr_base, snapBase);

        // Random traffic: jittery toggle, occasional silences, loads
        // (legal and illegal) and mid-run resets.
        p = 1'b1;
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [8:0] le;
            bit ld;
            bit r;
            if (hold > 0) hold--;
            else if ($urandom_range(0, 199) == 0) hold = $urandom_range(10, 30);
            else if ($urandom_range(0, 2) == 0) p = ~p;
            rnd = {$urandom, $urandom};
            ld  = ($urandom_range(0, 15) == 0);
            le  = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 299))
                                              : 9'($urandom_range(290, 511));
            r   = ($urandom_range(0, 299) == 0);
            applyStimulus(r, p, ld, rnd[32:0], le);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
